serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that consumes two WIDTH-bit operands over a valid/ready handshake and produces the sum DIGIT bits per clock through a ripple chain of full adders, carrying between cycles in a register. It is the sequential successor to the team's combinational half/full adder cells. It is used where area matters more than latency, and it adds a subtract mode plus carry and signed-overflow flags.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_if.sv | 30 +++
 rtl/full_adder.sv | 24 ++
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and elaboration helpers for the serial adder.
//   state_t          - FSM state encoding (IDLE, RUN, DONE)
//   width_digit_ok() - legality check for the WIDTH/DIGIT parameter pair
//   cnt_width()      - digit counter width, never less than one bit
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // WIDTH must be at least 2 and an exact multiple of DIGIT.
  function automatic bit width_digit_ok(int unsigned width, int unsigned digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  function automatic int unsigned cnt_width(int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   in_valid/in_ready   - operand handshake (a, b, cin, sub)
//   out_valid/out_ready - result handshake (sum, cout, ovf)
//   master modport: the requester; slave modport: the adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/full_adder.sv
// full_adder: one-bit full adder built from two half-adder stages and an OR.
//   a_i, b_i, cin_i - addends and carry in
//   sum_o, cout_o   - sum bit and carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic p;
  logic g_ab;
  logic g_pc;

  // First half adder: a + b.
  assign p     = a_i ^ b_i;
  assign g_ab  = a_i & b_i;
  // Second half adder: partial sum + carry in.
  assign sum_o = p ^ cin_i;
  assign g_pc  = p & cin_i;
  // The two half-adder carries are never both set, so OR suffices.
  assign cout_o = g_ab | g_pc;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor processing DIGIT bits per clock.
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - serial_adder_if slave: operands in (a, b, cin, sub) over
//          in_valid/in_ready; result out (sum, cout, ovf) over out_valid/out_ready.
// sub=1 computes a + ~b + 1 (cin ignored). cout is the carry out of the MSB
// (1 = no borrow when subtracting); ovf is signed overflow.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  import serial_adder_pkg::*;

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  if (!width_digit_ok(WIDTH, DIGIT)) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] dig_sum;
  logic [DIGIT:0]   chain_c;
  logic [WIDTH-1:0] sum_shift;

  // Ripple chain over the low DIGIT bits of the operand shift registers.
  assign chain_c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    full_adder u_fa (
      .a_i   (a_q[i]),
      .b_i   (b_q[i]),
      .cin_i (chain_c[i]),
      .sum_o (dig_sum[i]),
      .cout_o(chain_c[i+1])
    );
  end

  // New digit enters at the top; after STEPS shifts the first digit is at bit 0.
  always_comb begin
    sum_shift = sum_q >> DIGIT;
    sum_shift[WIDTH-1 -: DIGIT] = dig_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_shift;
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= chain_c[DIGIT];
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            cout_q  <= chain_c[DIGIT];
            // Carry into the MSB is the carry out of the chain's next-to-top stage.
            ovf_q   <= chain_c[DIGIT] ^ chain_c[DIGIT-1];
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8/DIGIT=1 and
// WIDTH=16/DIGIT=4 (the latter with out_ready tied high).
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  assign bus16.out_ready = 1'b1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8.slave)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk),
    .rst(rst),
    .bus(bus16.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents operands for one accept edge, then scrambles them.
  task automatic accept8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
    int guard;
    guard = 0;
    while (!bus8.in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk({tag, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
    bus8.sub      = sub;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    bus8.a        = ~a;
    bus8.b        = ~b;
    bus8.cin      = ~cin;
    bus8.sub      = ~sub;
  endtask

  // Counts cycles from the accept cycle (0) to the first cycle with out_valid.
  task automatic wait_out8(output int lat);
    lat = 1;
    while (!bus8.out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic cin, input logic sub,
                     input logic [7:0] es, input logic ec, input logic ev);
    int lat;
    accept8(tag, a, b, cin, sub);
    wait_out8(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_sum"},  32'(bus8.sum),  32'(es));
    chk({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
    chk({tag, "_ovf"},  32'(bus8.ovf),  32'(ev));
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    chk({tag, "_ready_after"}, 32'(bus8.in_ready),  32'd1);
    chk({tag, "_valid_after"}, 32'(bus8.out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int seen;
    int first_acc;
    int second_acc;

    rst            = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.sub       = 1'b0;
    bus16.in_valid = 1'b0;
    bus16.a        = '0;
    bus16.b        = '0;
    bus16.cin      = 1'b0;
    bus16.sub      = 1'b0;
    // in_valid during reset must be ignored
    step();
    bus8.in_valid = 1'b1;
    step();
    step();
    bus8.in_valid = 1'b0;
    rst           = 1'b0;

    // Reset state
    chk("rst_in_ready",   32'(bus8.in_ready),   32'd1);
    chk("rst_out_valid",  32'(bus8.out_valid),  32'd0);
    chk("rst_sum",        32'(bus8.sum),        32'd0);
    chk("rst_cout",       32'(bus8.cout),       32'd0);
    chk("rst_ovf",        32'(bus8.ovf),        32'd0);
    chk("rst16_in_ready", 32'(bus16.in_ready),  32'd1);
    chk("rst16_out_valid", 32'(bus16.out_valid), 32'd0);

    // Add, wrap-around, signed overflow
    op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_cin",   8'h20, 8'h03, 1'b1, 1'b0, 8'h24, 1'b0, 1'b0);
    // Subtract; cin must be ignored
    op8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Back-pressure: hold DONE for 5 cycles, stray in_valid pulse mid-way
    accept8("bp", 8'h10, 8'h20, 1'b0, 1'b0);
    wait_out8(lat);
    chk("bp_latency", 32'(lat), 32'd9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum",       32'(bus8.sum),       32'h30);
      chk("bp_cout",      32'(bus8.cout),      32'd0);
      chk("bp_ovf",       32'(bus8.ovf),       32'd0);
      chk("bp_in_ready",  32'(bus8.in_ready),  32'd0);
      chk("bp_out_valid", 32'(bus8.out_valid), 32'd1);
      if (i == 1) begin
        bus8.a        = 8'h01;
        bus8.b        = 8'h01;
        bus8.sub      = 1'b0;
        bus8.in_valid = 1'b1;
      end else begin
        bus8.in_valid = 1'b0;
      end
      step();
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    chk("bp_ready_after", 32'(bus8.in_ready),  32'd1);
    chk("bp_valid_after", 32'(bus8.out_valid), 32'd0);
    step();
    step();
    chk("bp_stray_not_taken", 32'(bus8.in_ready), 32'd1);

    // Reset in the third RUN cycle discards the operation
    accept8("mid_rst", 8'h11, 8'h22, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready",  32'(bus8.in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("mid_rst_sum",       32'(bus8.sum),       32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.out_valid) seen++;
      step();
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    op8("after_rst", 8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);

    // WIDTH=16, DIGIT=4
    bus16.a        = 16'hFFFF;
    bus16.b        = 16'h0001;
    bus16.cin      = 1'b0;
    bus16.sub      = 1'b0;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    bus16.a        = 16'h5555;
    lat = 1;
    while (!bus16.out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("w16_latency", 32'(lat),        32'd5);
    chk("w16_sum",     32'(bus16.sum),  32'h0000);
    chk("w16_cout",    32'(bus16.cout), 32'd1);
    chk("w16_ovf",     32'(bus16.ovf),  32'd0);
    step();
    chk("w16_ready_after", 32'(bus16.in_ready), 32'd1);

    bus16.a        = 16'h1000;
    bus16.b        = 16'h0001;
    bus16.sub      = 1'b1;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    bus16.sub      = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("w16_sub_latency", 32'(lat),        32'd5);
    chk("w16_sub_sum",     32'(bus16.sum),  32'h0FFF);
    chk("w16_sub_cout",    32'(bus16.cout), 32'd1);
    chk("w16_sub_ovf",     32'(bus16.ovf),  32'd0);
    step();

    // Back-to-back with in_valid held: accepts should be 6 cycles apart
    bus16.a        = 16'h1234;
    bus16.b        = 16'h1111;
    bus16.cin      = 1'b0;
    bus16.sub      = 1'b0;
    bus16.in_valid = 1'b1;
    first_acc  = -1;
    second_acc = -1;
    seen       = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (bus16.in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        else if (second_acc < 0) second_acc = cyc;
      end
      if (bus16.out_valid) begin
        seen++;
        chk("w16_b2b_sum", 32'(bus16.sum), 32'h2345);
      end
      step();
    end
    bus16.in_valid = 1'b0;
    chk("w16_b2b_first",   32'(first_acc),              32'd0);
    chk("w16_b2b_ii",      32'(second_acc - first_acc), 32'd6);
    chk("w16_b2b_results", 32'(seen),                   32'd3);
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
